// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive frame sequencer: preamble/SFD hunt, byte write-through (1-cycle latency), length/CRC qualification.
// No backpressure: the frame buffer must accept every Wr_En. Optional DA filter under ETH_RX_MAC_FILTER_EN.
module eth_rx_frame_ctrl #(
  parameter int          pMIN_PRE     = 8,
  parameter int          pMIN_LEN     = 64,
  parameter int          pMAX_LEN     = 1518,
  parameter int          pCRC_LAT     = 3,
  parameter logic [31:0] pCRC_RESIDUE = 32'hC704DD7B,
  parameter logic [47:0] pMAC_ADDR    = 48'h02_00_00_00_00_01
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Crs_Dv,
  input  logic [1:0]  Rxd,
  input  logic        Byte_Rdy,
  input  logic [7:0]  Byte,
  input  logic [31:0] Crc_Recv,
  output logic        Rx_En,
  output logic        Crc_En,
  output logic        Wr_En,
  output logic [7:0]  Wr_Data,
  output logic        Frame_Done,
  output logic        Frame_Ok,
  output logic [10:0] Frame_Len,
`ifdef ETH_RX_MAC_FILTER_EN
  output logic [3:0]  Err
`else
  output logic [2:0]  Err
`endif
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, CHECK} state_t;

  localparam logic [4:0]  MIN_PRE  = 5'(pMIN_PRE);
  localparam logic [10:0] MIN_LEN  = 11'(pMIN_LEN);
  localparam logic [10:0] MAX_LEN  = 11'(pMAX_LEN);
  localparam logic [7:0]  CHK_LAST = 8'(pCRC_LAT - 1);
  localparam logic [7:0]  CHK_END  = 8'(pCRC_LAT);

  state_t      state, next_state;
  logic [4:0]  pre_cnt;
  logic [10:0] len;
  logic        low_seen;
  logic [7:0]  chk_cnt;
  logic        oversize;
  logic        chk_fire;
  logic        runt;
  logic        crc_bad;

  assign runt    = len < MIN_LEN;
  assign crc_bad = Crc_Recv != pCRC_RESIDUE;

`ifdef ETH_RX_MAC_FILTER_EN
  logic [47:0] da_sr;
  logic        filtered;
  logic [3:0]  err_vec;

  // Frames too short to carry a full DA cannot match any address.
  assign filtered = (len < 11'd6) || !((da_sr == pMAC_ADDR) || (da_sr == 48'hFFFF_FFFF_FFFF));
  assign err_vec  = {filtered, oversize, runt, crc_bad};
`else
  logic [2:0]  err_vec;

  assign err_vec = {oversize, runt, crc_bad};
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    Rx_En      = 1'b0;
    Crc_En     = 1'b0;
    chk_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (Crs_Dv && (Rxd == 2'b01)) next_state = PRE;
      end
      PRE: begin
        if (!Crs_Dv)              next_state = IDLE;
        else if (Rxd == 2'b11)    next_state = (pre_cnt >= MIN_PRE) ? DATA : IDLE;
        else if (Rxd != 2'b01)    next_state = IDLE;
      end
      DATA: begin
        Rx_En  = 1'b1;
        Crc_En = 1'b1;
        // One low cycle is the RMII CRS_DV toggle; two in a row is end of carrier.
        if (!Crs_Dv && low_seen) next_state = CHECK;
      end
      CHECK: begin
        if (chk_cnt == CHK_LAST) chk_fire = 1'b1;
        if (chk_cnt == CHK_END)  next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pre_cnt    <= 5'd0;
      len        <= 11'd0;
      low_seen   <= 1'b0;
      chk_cnt    <= 8'd0;
      oversize   <= 1'b0;
      Wr_En      <= 1'b0;
      Wr_Data    <= 8'd0;
      Frame_Done <= 1'b0;
      Frame_Ok   <= 1'b0;
      Frame_Len  <= 11'd0;
      Err        <= '0;
`ifdef ETH_RX_MAC_FILTER_EN
      da_sr      <= 48'd0;
`endif
    end else begin
      Wr_En      <= 1'b0;
      Frame_Done <= 1'b0;
      case (state)
        IDLE: begin
          pre_cnt  <= 5'd1;
          len      <= 11'd0;
          low_seen <= 1'b0;
          chk_cnt  <= 8'd0;
          oversize <= 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
          da_sr    <= 48'd0;
`endif
        end
        PRE: begin
          if ((Rxd == 2'b01) && (pre_cnt != 5'd31)) pre_cnt <= pre_cnt + 5'd1;
        end
        DATA: begin
          low_seen <= !Crs_Dv;
          if (Byte_Rdy) begin
            if (len != 11'h7FF) len <= len + 11'd1;
            if (len < MAX_LEN) begin
              Wr_En   <= 1'b1;
              Wr_Data <= Byte;
            end else begin
              oversize <= 1'b1;
            end
`ifdef ETH_RX_MAC_FILTER_EN
            if (len < 11'd6) da_sr <= {da_sr[39:0], Byte};
`endif
          end
        end
        CHECK: begin
          chk_cnt <= chk_cnt + 8'd1;
          if (chk_fire) begin
            Frame_Done <= 1'b1;
            Frame_Len  <= len;
            Err        <= err_vec;
            Frame_Ok   <= ~|err_vec;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: a task plays RMII frames and queues expected writes/status,
// a negedge monitor pops and compares whenever Wr_En or Frame_Done is presented.
module tb_eth_rx_frame_ctrl;

`ifdef ETH_RX_MAC_FILTER_EN
  localparam int ERR_W = 4;
`else
  localparam int ERR_W = 3;
`endif
  localparam logic [31:0] RES  = 32'hC704DD7B;
  localparam logic [47:0] MAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHR = 48'h02_00_00_00_00_02;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             Crs_Dv = 1'b0;
  logic [1:0]       Rxd = 2'b00;
  logic             Byte_Rdy = 1'b0;
  logic [7:0]       Byte = 8'h00;
  logic [31:0]      Crc_Recv = 32'h0;
  logic             Rx_En, Crc_En, Wr_En, Frame_Done, Frame_Ok;
  logic [7:0]       Wr_Data;
  logic [10:0]      Frame_Len;
  logic [ERR_W-1:0] Err;

  eth_rx_frame_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(Crs_Dv), .Rxd(Rxd), .Byte_Rdy(Byte_Rdy), .Byte(Byte),
    .Crc_Recv(Crc_Recv), .Rx_En(Rx_En), .Crc_En(Crc_En), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
    .Frame_Done(Frame_Done), .Frame_Ok(Frame_Ok), .Frame_Len(Frame_Len), .Err(Err)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic             ok;
    logic [10:0]      len;
    logic [ERR_W-1:0] err;
  } stat_t;

  logic [7:0] wr_q[$];
  stat_t      stat_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         watch_rx = 1'b0;
  int         rx_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a frame status.
  always @(negedge Clk) begin
    stat_t s;
    if (watch_rx && (Rx_En || Crc_En)) rx_hits++;
    if (Wr_En) begin
      if (wr_q.size() == 0) chk("unexpected_wr_en", 32'(Wr_Data), 32'hDEAD);
      else                  chk("wr_data", 32'(Wr_Data), 32'(wr_q.pop_front()));
    end
    if (Frame_Done) begin
      if (stat_q.size() == 0) chk("unexpected_frame_done", 32'(Frame_Len), 32'hDEAD);
      else begin
        s = stat_q.pop_front();
        chk("frame_ok",  32'(Frame_Ok),  32'(s.ok));
        chk("frame_len", 32'(Frame_Len), 32'(s.len));
        chk("err",       32'(Err),       32'(s.err));
      end
    end
  end

  task automatic drive(input logic dv, input logic [1:0] d);
    @(posedge Clk); #1;
    Crs_Dv   = dv;
    Rxd      = d;
    Byte_Rdy = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rx_en"},  32'(Rx_En),      32'd0);
    chk({tag, "_crc_en"}, 32'(Crc_En),     32'd0);
    chk({tag, "_wr_en"},  32'(Wr_En),      32'd0);
    chk({tag, "_done"},   32'(Frame_Done), 32'd0);
    chk({tag, "_ok"},     32'(Frame_Ok),   32'd0);
    chk({tag, "_len"},    32'(Frame_Len),  32'd0);
    chk({tag, "_err"},    32'(Err),        32'd0);
  endtask

  task automatic idle_and_drain(input int cycles);
    repeat (cycles) drive(1'b0, 2'b00);
    chk("drain_wr",   32'(wr_q.size()),   32'd0);
    chk("drain_stat", 32'(stat_q.size()), 32'd0);
  endtask

  // Plays 7x55 + D5, then nbytes bytes (DA first) LSB-dibit first, Byte_Rdy on each 4th dibit.
  task automatic send_frame(input int nbytes, input bit crc_good, input logic [47:0] da,
                            input int seed, input int glitch_byte, input int rst_byte);
    logic [7:0]       b;
    stat_t            s;
    logic [ERR_W-1:0] e;
    Crc_Recv = 32'h0;
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_byte) begin
        @(posedge Clk); #1;
        Rst = 1'b1; Byte_Rdy = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check_outputs_zero("midframe_rst");
        Rst = 1'b0; Crs_Dv = 1'b0; Rxd = 2'b00;
        idle_and_drain(20);
        return;
      end
      b = (i < 6) ? da[47 - 8*i -: 8] : 8'(i * 7 + seed);
      if (i < 1518) wr_q.push_back(b);
      for (int d = 0; d < 4; d++) begin
        @(posedge Clk); #1;
        Crs_Dv   = !((i == glitch_byte) && (d == 1));
        Rxd      = b[2*d +: 2];
        Byte_Rdy = (d == 3);
        Byte     = b;
      end
    end
    Crc_Recv = crc_good ? RES : (RES ^ 32'h0000_00FF);
    e[0] = !crc_good;
    e[1] = nbytes < 64;
    e[2] = nbytes > 1518;
`ifdef ETH_RX_MAC_FILTER_EN
    e[3] = (nbytes < 6) || !((da == MAC) || (da == BCST));
`endif
    s.ok  = (e == '0);
    s.len = (nbytes > 2047) ? 11'd2047 : 11'(nbytes);
    s.err = e;
    stat_q.push_back(s);
    idle_and_drain(20);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_outputs_zero("reset");
    Rst = 1'b0;
    repeat (3) drive(1'b0, 2'b00);

    send_frame(64, 1'b1, MAC, 3, -1, -1);          // good frame
    chk("hold_ok",  32'(Frame_Ok),  32'd1);
    chk("hold_len", 32'(Frame_Len), 32'd64);
    send_frame(64, 1'b0, MAC, 5, -1, -1);          // bad FCS
    send_frame(40, 1'b1, MAC, 9, -1, -1);          // runt
    send_frame(1600, 1'b1, MAC, 1, -1, -1);        // oversize

    // Short preamble: 4x 01 then SFD must never open the frame.
    watch_rx = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 2'b10);
      Byte_Rdy = ((i % 4) == 3);
      Byte     = 8'hA5;
    end
    idle_and_drain(20);
    watch_rx = 1'b0;
    chk("short_pre_rx_en", 32'(rx_hits), 32'd0);

    send_frame(64, 1'b1, MAC, 11, 20, -1);         // single-cycle Crs_Dv drop mid-frame
    send_frame(64, 1'b1, MAC, 13, -1, 30);         // reset at byte 30
    send_frame(70, 1'b1, MAC, 17, -1, -1);         // good frame after reset
`ifdef ETH_RX_MAC_FILTER_EN
    send_frame(64, 1'b1, BCST, 19, -1, -1);
    send_frame(64, 1'b1, OTHR, 23, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
